// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the byte-wide memory port between fetch and LSB.
// Serialises word/half/byte requests into per-byte accesses, little-endian.
module mem_port_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_ready,
    input  logic              lsb_req,
    input  logic              lsb_we,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic [31:0]       lsb_rdata,
    output logic              lsb_ready,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic              if_pend_q, if_pend_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d;
    logic              lsb_pend_q, lsb_pend_d;
    logic              lsb_we_q, lsb_we_d;
    logic [1:0]        lsb_size_q, lsb_size_d;
    logic [ADDR_W-1:0] lsb_addr_q, lsb_addr_d;
    logic [31:0]       lsb_wdata_q, lsb_wdata_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_lsb_q, cur_lsb_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_ready_q, if_ready_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              lsb_ready_q, lsb_ready_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_a;
    logic [2:0]        n_cur;
    logic [1:0]        bidx;
    logic              if_busy, lsb_busy;
    logic              if_cand, lsb_cand;
    logic              grant_lsb, grant_if;

    always_comb begin
        state_d      = state_q;
        if_pend_d    = if_pend_q;
        if_addr_d    = if_addr_q;
        lsb_pend_d   = lsb_pend_q;
        lsb_we_d     = lsb_we_q;
        lsb_size_d   = lsb_size_q;
        lsb_addr_d   = lsb_addr_q;
        lsb_wdata_d  = lsb_wdata_q;
        last_grant_d = last_grant_q;
        cur_lsb_d    = cur_lsb_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        if_ready_d   = 1'b0;
        if_data_d    = '0;
        lsb_ready_d  = 1'b0;
        lsb_rdata_d  = '0;

        if_busy   = (state_q != S_IDLE) && !cur_lsb_q;
        lsb_busy  = (state_q != S_IDLE) && cur_lsb_q;
        if_cand   = 1'b0;
        lsb_cand  = 1'b0;
        grant_lsb = 1'b0;
        grant_if  = 1'b0;

        unique case (lsb_size_q)
            2'b00:   n_cur = 3'd1;
            2'b01:   n_cur = 3'd2;
            default: n_cur = 3'd4;
        endcase
        if (!cur_lsb_q) n_cur = 3'd4;

        base   = cur_lsb_q ? lsb_addr_q : if_addr_q;
        next_a = base + {{(ADDR_W-3){1'b0}}, cnt_q};
        bidx   = cnt_q[1:0] - 2'd1;

        // Pulses land in the pend registers first so IDLE can grant them same-edge
        if (if_req && !if_pend_q && !if_busy) begin
            if_pend_d = 1'b1;
            if_addr_d = if_addr;
        end
        if (flush) if_pend_d = 1'b0;
        if (lsb_req && !lsb_pend_q && !lsb_busy) begin
            lsb_pend_d  = 1'b1;
            lsb_we_d    = lsb_we;
            lsb_size_d  = lsb_size;
            lsb_addr_d  = lsb_addr;
            lsb_wdata_d = lsb_wdata;
        end

        unique case (state_q)
            S_IDLE: begin
                if_cand   = if_pend_d;
                lsb_cand  = lsb_pend_d &&
                            !(lsb_we_d && lsb_addr_d[17:16] == IO_HI && io_buffer_full);
                grant_lsb = lsb_cand && (!if_cand || !last_grant_q);
                grant_if  = if_cand && !grant_lsb;
                if (grant_lsb) begin
                    lsb_pend_d   = 1'b0;
                    cur_lsb_d    = 1'b1;
                    last_grant_d = 1'b1;
                    mem_a_d      = lsb_addr_d;
                    cnt_d        = 3'd1;
                    asm_d        = '0;
                    if (lsb_we_d) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = lsb_wdata_d[7:0];
                        state_d    = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end else if (grant_if) begin
                    if_pend_d    = 1'b0;
                    cur_lsb_d    = 1'b0;
                    last_grant_d = 1'b0;
                    mem_a_d      = if_addr_d;
                    cnt_d        = 3'd1;
                    asm_d        = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (flush && !cur_lsb_q) begin
                    state_d = S_IDLE;
                    mem_a_d = '0;
                end else begin
                    asm_d[{bidx, 3'b000} +: 8] = mem_din;
                    if (cnt_q < n_cur) begin
                        mem_a_d = next_a;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        state_d = S_IDLE;
                        mem_a_d = '0;
                        if (cur_lsb_q) begin
                            lsb_ready_d = 1'b1;
                            lsb_rdata_d = asm_d;
                        end else begin
                            if_ready_d = 1'b1;
                            if_data_d  = asm_d;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q < n_cur) begin
                    mem_a_d    = next_a;
                    mem_dout_d = lsb_wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    state_d     = S_IDLE;
                    mem_wr_d    = 1'b0;
                    mem_a_d     = '0;
                    mem_dout_d  = '0;
                    lsb_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= S_IDLE;
            if_pend_q    <= 1'b0;
            if_addr_q    <= '0;
            lsb_pend_q   <= 1'b0;
            lsb_we_q     <= 1'b0;
            lsb_size_q   <= '0;
            lsb_addr_q   <= '0;
            lsb_wdata_q  <= '0;
            last_grant_q <= 1'b0;
            cur_lsb_q    <= 1'b0;
            cnt_q        <= '0;
            asm_q        <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            if_ready_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_ready_q  <= 1'b0;
            lsb_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            if_pend_q    <= if_pend_d;
            if_addr_q    <= if_addr_d;
            lsb_pend_q   <= lsb_pend_d;
            lsb_we_q     <= lsb_we_d;
            lsb_size_q   <= lsb_size_d;
            lsb_addr_q   <= lsb_addr_d;
            lsb_wdata_q  <= lsb_wdata_d;
            last_grant_q <= last_grant_d;
            cur_lsb_q    <= cur_lsb_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            if_ready_q   <= if_ready_d;
            if_data_q    <= if_data_d;
            lsb_ready_q  <= lsb_ready_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    assign if_data   = if_data_q;
    assign if_ready  = if_ready_q;
    assign lsb_rdata = lsb_rdata_q;
    assign lsb_ready = lsb_ready_q;
    assign mem_dout  = mem_dout_q;
    assign mem_a     = mem_a_q;
    assign mem_wr    = mem_wr_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide unified memory port between the instruction fetch unit and the load/store buffer (LSB).
- Accepts one outstanding request from each requester and grants them round-robin.
- Serialises each grant into per-byte memory accesses, assembles read data little-endian, and returns it with a one-cycle ready pulse.
- Sits between the fetch unit / LSB and the external RAM / IO bus.

Parameters:
- ADDR_W, 32, address width of requests and of mem_a.
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clear  in  1  synchronous active-high reset.
- flush  in  1  pipeline redirect; aborts or drops the fetch transaction.
- if_req  in  1  one-cycle fetch request pulse.
- if_addr  in  ADDR_W  fetch address, sampled with if_req.
- if_data  out  32  fetched word, valid while if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- lsb_req  in  1  one-cycle load/store request pulse.
- lsb_we  in  1  1 = store, 0 = load.
- lsb_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- lsb_addr  in  ADDR_W  byte address.
- lsb_wdata  in  32  store data, low bytes used.
- lsb_rdata  out  32  load data, zero-extended, valid while lsb_ready=1.
- lsb_ready  out  1  one-cycle load/store completion pulse.
- io_buffer_full  in  1  IO sink cannot accept writes.
- mem_din  in  8  read byte for the address driven on the previous cycle.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_W  byte address.
- mem_wr  out  1  1 = write this cycle.

Behaviour:
- **Reset.** clear=1 at a posedge applies reset; it has priority over every other input.
  - State = IDLE.
  - if_pend = 0, lsb_pend = 0, last_grant = IF.
  - All outputs = 0.
  - Any transaction in flight is abandoned, including a partly written store.
- **Request latching.** On if_req, capture if_addr and set if_pend. On lsb_req, capture the lsb_* fields and set lsb_pend.
  - A request pulse while the same requester is pending or busy is ignored.
- **States:** IDLE, READ, WRITE.
  - Byte count N = 1, 2 or 4 per lsb_size; N = 4 for fetch.
  - Byte counter cnt is 3 bits.
- **Grant.** In IDLE the candidate set is the pending requests, plus any request pulse arriving on the same edge (zero-cycle grant).
  - If both are candidates, grant the one not equal to last_grant.
  - Update last_grant on every grant.
  - Clear the granted pend bit at grant.
- **Read (fetch or load).**
  - Grant edge E0: mem_a <= base, mem_wr <= 0, cnt <= 1, state <= READ.
  - Each edge in READ: capture mem_din into byte cnt-1 of the assembly register. If cnt < N, issue mem_a <= base+cnt and cnt++.
  - Edge E_N (capturing byte N-1): pulse the matching ready for exactly one cycle with the assembled data; state <= IDLE; mem_a <= 0.
  - The next grant is not evaluated before E_N+1.
  - Latency: ready is high in the cycle after edge E_N. Word = 4 edges after grant; byte = 1 edge.
- **Write (store).**
  - If lsb_addr[17:16] == IO_HI and io_buffer_full = 1, the store is not granted and stays pending. IF may be granted meanwhile.
  - Grant edge E0: mem_a <= base, mem_dout <= wdata[7:0], mem_wr <= 1, state <= WRITE.
  - Edges E1..E(N-1): next address and byte.
  - Edge E_N: mem_wr <= 0, mem_a <= 0, lsb_ready pulse, state <= IDLE.
  - A store is never aborted by flush.
- **Flush.** Clears if_pend and ignores a same-edge if_req.
  - If the current transaction is a fetch: abandon it, state <= IDLE, no if_ready.
  - Load/store transactions and lsb_pend are unaffected.
  - A fetch completing on the same edge as flush does not pulse if_ready.
- **Widths.**
  - Address increment wraps modulo 2^ADDR_W.
  - The data buffer bytes not read on a load are 0.
  - Outputs if_data and lsb_rdata return to 0 when their ready deasserts.
- mem_wr is 0 in every cycle except WRITE byte cycles.

Test Plan:
1. RAM[0x100..0x103] = 13 05 00 00. Pulse if_req with if_addr=0x100 → mem_a steps 0x100..0x103, mem_wr=0 throughout; if_ready high 4 edges after grant with if_data=0x00000513.
2. Same-edge if_req (0x200) and lsb_req (load word 0x1000) after reset, last_grant=IF → LSB served first; IF granted on the edge after lsb_ready; both ready exactly once.
3. lsb_req store half, addr=0x1002, wdata=0xAABBCCDD → mem_wr=1 for 2 cycles writing CC then DD... precisely DD at 0x1002 then CC at 0x1003; lsb_ready 2 edges after grant; RAM[0x1002..3] = DD CC.
4. Store byte to 0x30000 with io_buffer_full=1 for 5 cycles, plus a pending fetch → fetch completes first; the store is granted on the first edge with io_buffer_full=0.
5. Fetch in flight (after 2 bytes) and flush=1 → no if_ready, state IDLE next cycle; a subsequent if_req at 0x300 returns correct data.
6. Assert clear during a word store after byte 1 → mem_wr=0, all outputs 0 next cycle, no lsb_ready.
